tb_uart: RTL and testbench
==========================

// Module: tb_uart
// PURPOSE
//  Synthesizable 8-bit UART receiver/monitor on the chip's UART TX pin (mprj_io[6]).
//  Deserialises 8N1 frames and reports each byte with a one-cycle valid strobe.
//  Flags framing errors, line-feed characters and a received-byte count for self-checking benches.
//  Sits beside the SoC top as a passive observer; it never drives the line.
// PARAMETERS
//  CLKS_PER_BIT  4167  clock cycles per UART bit (40 MHz / 9600 baud); legal range >= 8
// PORTS
//  clock          in   1   system clock; all state on rising edge
//  resetb         in   1   reset, asynchronous, active-low
//  ser_rx         in   1   serial data in, idle high, asynchronous to clock
//  rx_data        out  8   last accepted byte (LSB received first)
//  rx_valid       out  1   1-cycle pulse: rx_data updated this cycle
//  rx_frame_err   out  1   1-cycle pulse: stop bit sampled low
//  rx_parity_err  out  1   1-cycle pulse: parity mismatch (tied 0 without TB_UART_PARITY_EN)
//  line_end       out  1   1-cycle pulse, coincident with rx_valid when the byte is 8'h0A
//  rx_busy        out  1   high whenever the FSM is not IDLE
//  char_count     out  16  number of accepted bytes, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (any time, including mid-frame): FSM -> IDLE; rx_data=8'h00; all pulses=0;
//    rx_busy=0; char_count=0; synchroniser flops preset to 1.
//  - ser_rx passes through a 2-flop synchroniser; the FSM sees only the synchronised value.
//  - IDLE: a synchronised falling edge (1->0) -> START, baud counter cleared.
//  - START: at count CLKS_PER_BIT/2-1, sample. Low -> DATA (counter cleared, bit index 0);
//    high -> glitch, return to IDLE with no output pulse.
//  - DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift in LSB-first; after bit 7 ->
//    PARITY if macro defined, else STOP.
//  - STOP: sample after CLKS_PER_BIT. High -> rx_data<=shift reg, rx_valid=1,
//    char_count+1 (saturating), line_end=1 if byte==8'h0A, -> IDLE.
//    Low -> rx_frame_err=1, rx_data unchanged, count unchanged, -> BREAK.
//  - BREAK: wait until synchronised line is high, then -> IDLE (a held-low line does not retrigger).
//  - Latency: rx_valid asserts at the mid-point of the stop bit (+2 sync cycles).
//  - Pulses are registered and never overlap rx_valid with an error pulse.
//  - Baud counter width = $clog2(CLKS_PER_BIT); bit index 3 bits, no wrap beyond 7.
// CONFIGURATION
//  TB_UART_PARITY_EN defined: frame is 8E1; PARITY state samples one extra bit after bit 7;
//    even parity over data+parity bit must be 0, else rx_parity_err pulse, no rx_valid,
//    rx_data/count unchanged, then STOP still sampled (stop low -> BREAK, no frame_err
//    pulse in the same frame; at most one error pulse per frame).
//  Not defined: 8N1, PARITY state absent, rx_parity_err constant 0.
// STRUCTURE
//  - Package tb_uart_pkg: state enum {IDLE, START, DATA, PARITY, STOP, BREAK}; ASCII_LF=8'h0A.
//  - Sub-module tb_uart_sync: 2-flop synchroniser, async active-low reset presetting to 1.
//  - Top: FSM, baud counter, shift register, output registers, char counter.
// TESTING (bench uses CLKS_PER_BIT=16)
//  1. resetb=0 with ser_rx toggling -> rx_valid=0, rx_busy=0, rx_data=8'h00, char_count=0.
//  2. Send 8'h41 8N1 -> exactly one rx_valid, rx_data=8'h41, char_count=1, line_end=0.
//  3. Send 8'h0A -> rx_valid and line_end high in same cycle; char_count increments.
//  4. Send 8'h55 with stop bit 0, hold low 40 clocks -> one rx_frame_err, no rx_valid,
//     rx_data keeps prior value, no new frame until line returns high.
//  5. Low glitch of 4 clocks on idle line -> no pulse, rx_busy returns 0 within 10 clocks.
//  6. TB_UART_PARITY_EN: 8'h41 with parity bit 1 -> rx_parity_err pulse, no rx_valid;
//     parity bit 0 -> rx_valid, rx_data=8'h41. Also assert resetb mid-DATA -> IDLE, count unchanged=0.

Source files
------------

// File: rtl/tb_uart_pkg.sv
// Shared types and constants for the tb_uart passive UART receiver/monitor.
package tb_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/tb_uart_sync.sv
// Two-flop synchroniser for the asynchronous serial line; presets to idle-high on reset.
module tb_uart_sync (
  input  logic clock,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tb_uart.sv
// Passive 8-bit UART receiver/monitor (8N1, or 8E1 when TB_UART_PARITY_EN is defined).
// Reports bytes, framing/parity errors, line-feeds and a saturating byte count.
module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4167
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        ser_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_frame_err,
  output logic        rx_parity_err,
  output logic        line_end,
  output logic        rx_busy,
  output logic [15:0] char_count
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t HALF = cnt_t'(CLKS_PER_BIT / 2 - 1);
  localparam cnt_t FULL = cnt_t'(CLKS_PER_BIT - 1);

  state_t     state;
  cnt_t       cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       rx_s;
  logic       rx_prev;

  tb_uart_sync u_sync (
    .clock  (clock),
    .resetb (resetb),
    .d      (ser_rx),
    .q      (rx_s)
  );

  assign rx_busy = (state != IDLE);

`ifdef TB_UART_PARITY_EN
  logic par_bad;
  logic par_err_q;
  assign rx_parity_err = par_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_prev      <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      line_end     <= 1'b0;
      char_count   <= '0;
`ifdef TB_UART_PARITY_EN
      par_bad      <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      line_end     <= 1'b0;
`ifdef TB_UART_PARITY_EN
      par_err_q    <= 1'b0;
`endif
      rx_prev      <= rx_s;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
`ifdef TB_UART_PARITY_EN
            par_bad <= 1'b0;
`endif
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef TB_UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
`ifdef TB_UART_PARITY_EN
        PARITY: begin
          if (cnt == FULL) begin
            cnt       <= '0;
            par_bad   <= (^shift) ^ rx_s;
            par_err_q <= (^shift) ^ rx_s;
            state     <= STOP;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
`ifdef TB_UART_PARITY_EN
            // A parity-failed frame already raised its one error pulse; only route the FSM.
            if (par_bad) begin
              state <= rx_s ? IDLE : BREAK;
            end else
`endif
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              line_end <= (shift == ASCII_LF);
              if (char_count != 16'hFFFF) char_count <= char_count + 16'd1;
              state    <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_uart.sv
// Self-checking bench for tb_uart: directed cases plus randomized frames against a byte-level model.
module tb_tb_uart;

  localparam int unsigned CPB = 16;

  logic        clock = 1'b0;
  logic        resetb;
  logic        ser_rx;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_frame_err, rx_parity_err, line_end, rx_busy;
  logic [15:0] char_count;

  int checks = 0;
  int failures = 0;

  int n_valid = 0, n_fe = 0, n_pe = 0, n_le = 0, n_le_bad = 0, n_overlap = 0;
  int s_valid, s_fe, s_pe, s_le;

  logic [7:0]  exp_data;
  logic [15:0] exp_count;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock         (clock),
    .resetb        (resetb),
    .ser_rx        (ser_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .line_end      (line_end),
    .rx_busy       (rx_busy),
    .char_count    (char_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid) n_valid++;
    if (rx_frame_err) n_fe++;
    if (rx_parity_err) n_pe++;
    if (line_end) n_le++;
    if (line_end != (rx_valid && rx_data == 8'h0A)) n_le_bad++;
    if (rx_valid && (rx_frame_err || rx_parity_err)) n_overlap++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    ser_rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  // Whole frame: start, 8 data LSB-first, [even parity], stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef TB_UART_PARITY_EN
    bit_out((^b) ^ par_flip);
`endif
    bit_out(stop_bit);
  endtask

  task automatic snap();
    s_valid = n_valid; s_fe = n_fe; s_pe = n_pe; s_le = n_le;
  endtask

  // Sends one frame, lets the line idle, and checks outcome against the byte-level model.
  task automatic frame_and_check(input string tag, input logic [7:0] b,
                                 input logic stop_ok, input logic par_flip);
    logic par_ok;
    logic accept;
`ifdef TB_UART_PARITY_EN
    par_ok = !par_flip;
`else
    par_ok = 1'b1;
`endif
    accept = par_ok && stop_ok;
    snap();
    send_frame(b, stop_ok, par_flip);
    ser_rx = 1'b1;
    repeat (24) @(negedge clock);
    if (accept) begin
      exp_data = b;
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    end
    check({tag, "_valid"}, n_valid - s_valid, accept ? 1 : 0);
    check({tag, "_ferr"}, n_fe - s_fe, (par_ok && !stop_ok) ? 1 : 0);
    check({tag, "_perr"}, n_pe - s_pe, par_ok ? 0 : 1);
    check({tag, "_lend"}, n_le - s_le, (accept && b == 8'h0A) ? 1 : 0);
    check({tag, "_data"}, rx_data, exp_data);
    check({tag, "_count"}, char_count, exp_count);
    check({tag, "_busy"}, rx_busy, 0);
  endtask

  initial begin
    int k;
    logic [7:0] rb;
    exp_data = 8'h00;
    exp_count = 16'd0;

    // Reset with a toggling line
    resetb = 1'b0;
    ser_rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      ser_rx = ~ser_rx;
    end
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_count", char_count, 0);
    check("rst_ferr", rx_frame_err, 0);
    ser_rx = 1'b1;
    repeat (4) @(negedge clock);
    resetb = 1'b1;
    repeat (8) @(negedge clock);

    frame_and_check("byte41", 8'h41, 1'b1, 1'b0);
    frame_and_check("lf", 8'h0A, 1'b1, 1'b0);

    // Bad stop bit, line held low: one frame error, then no retrigger while low
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    check("brk_ferr", n_fe - s_fe, 1);
    check("brk_valid", n_valid - s_valid, 0);
    check("brk_data", rx_data, exp_data);
    check("brk_count", char_count, exp_count);
    check("brk_busy_low", rx_busy, 1);
    ser_rx = 1'b1;
    repeat (8) @(negedge clock);
    check("brk_busy_rel", rx_busy, 0);
    check("brk_ferr_once", n_fe - s_fe, 1);

    // Short low glitch on an idle line
    snap();
    ser_rx = 1'b0;
    repeat (4) @(negedge clock);
    ser_rx = 1'b1;
    k = 0;
    while (rx_busy && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("glitch_idle", rx_busy, 0);
    repeat (20) @(negedge clock);
    check("glitch_pulses", (n_valid - s_valid) + (n_fe - s_fe) + (n_pe - s_pe), 0);

`ifdef TB_UART_PARITY_EN
    frame_and_check("par_bad", 8'h41, 1'b1, 1'b1);
    frame_and_check("par_ok", 8'h41, 1'b1, 1'b0);
    frame_and_check("par_bad_stop", 8'h3C, 1'b0, 1'b1);
`endif

    // Reset asserted in the middle of the data bits
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    resetb = 1'b0;
    @(negedge clock);
    check("midrst_busy", rx_busy, 0);
    check("midrst_count", char_count, 0);
    check("midrst_data", rx_data, 8'h00);
    ser_rx = 1'b1;
    repeat (4) @(negedge clock);
    resetb = 1'b1;
    repeat (8) @(negedge clock);
    exp_data = 8'h00;
    exp_count = 16'd0;
    frame_and_check("postrst", 8'h41, 1'b1, 1'b0);

    // Randomized frames
    for (int i = 0; i < 14; i++) begin
      logic sok, pf;
      rb  = 8'($urandom_range(0, 255));
      if (i % 5 == 2) rb = 8'h0A;
      sok = ($urandom_range(0, 4) != 0);
`ifdef TB_UART_PARITY_EN
      pf  = ($urandom_range(0, 3) == 0);
`else
      pf  = 1'b0;
`endif
      frame_and_check($sformatf("rnd%0d", i), rb, sok, pf);
    end

    check("lend_coincident", n_le_bad, 0);
    check("no_overlap", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
